// File: rtl/simon_pkg.sv
// Shared encodings for the Simon press checker: FSM states, color codes,
// fail codes and the one-hot button helpers.
package simon_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] COL_RED    = 2'd0;
    localparam logic [1:0] COL_GREEN  = 2'd1;
    localparam logic [1:0] COL_YELLOW = 2'd2;
    localparam logic [1:0] COL_BLUE   = 2'd3;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_COLOR   = 2'b01;
    localparam logic [1:0] FC_TIMEOUT = 2'b10;
    localparam logic [1:0] FC_MULTI   = 2'b11;

    function automatic logic is_onehot4(input logic [3:0] b);
        return (b != 4'd0) && ((b & (b - 4'd1)) == 4'd0);
    endfunction

    // Only meaningful when exactly one bit is set.
    function automatic logic [1:0] encode_color(input logic [3:0] b);
        logic [1:0] c;
        c = COL_RED;
        if (b[1]) c = COL_GREEN;
        if (b[2]) c = COL_YELLOW;
        if (b[3]) c = COL_BLUE;
        return c;
    endfunction

endpackage

// File: rtl/timeout_counter.sv
// Idle-cycle counter: counts while enabled, saturates at LIMIT-1 and flags
// expiry there so it can never wrap back to zero.
module timeout_counter #(
    parameter int LIMIT = 250000
) (
    input  logic i_clk,
    input  logic i_n_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_n_reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LAST)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_expired = (r_count == LAST);

endmodule

// File: rtl/simon_input_checker.sv
// Checks player button presses against the stored Simon sequence for one
// round, reporting each press, round success, or the reason for failure.
module simon_input_checker
    import simon_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int TIMEOUT = 250000
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic [3:0] btn_pulse,
    input  logic       start,
    input  logic [4:0] round_len,
    input  logic [1:0] seq_color,
    output logic [3:0] seq_idx,
    output logic       busy,
    output logic       press_valid,
    output logic [1:0] press_color,
    output logic       round_ok,
    output logic       fail,
    output logic [1:0] fail_code
);
    state_t     r_state;
    logic [3:0] r_seq_idx;
    logic [4:0] r_len;
    logic       r_busy;
    logic       r_press_valid;
    logic [1:0] r_press_color;
    logic       r_round_ok;
    logic       r_fail;
    logic [1:0] r_fail_code;

    logic       w_any;
    logic       w_single;
    logic       w_multi;
    logic [1:0] w_color;
    logic       w_len_ok;
    logic       w_last;
    logic       w_in_wait;
    logic       w_expired;

    assign w_any     = |btn_pulse;
    assign w_single  = is_onehot4(btn_pulse);
    assign w_multi   = w_any && !w_single;
    assign w_color   = encode_color(btn_pulse);
    assign w_len_ok  = (round_len != 5'd0) && (round_len <= 5'(MAX_LEN));
    assign w_last    = ({1'b0, r_seq_idx} == (r_len - 5'd1));
    assign w_in_wait = (r_state == ST_WAIT);

    // Any press restarts the idle window; outside WAIT the timer is held at zero.
    timeout_counter #(.LIMIT(TIMEOUT)) u_timer (
        .i_clk     (clk),
        .i_n_reset (n_reset),
        .i_clear   (!w_in_wait || w_any),
        .i_enable  (w_in_wait),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_state       <= ST_IDLE;
            r_seq_idx     <= 4'd0;
            r_len         <= 5'd0;
            r_busy        <= 1'b0;
            r_press_valid <= 1'b0;
            r_press_color <= 2'd0;
            r_round_ok    <= 1'b0;
            r_fail        <= 1'b0;
            r_fail_code   <= FC_NONE;
        end else begin
            r_press_valid <= 1'b0;
            r_round_ok    <= 1'b0;
            r_fail        <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && w_len_ok) begin
                        r_state   <= ST_WAIT;
                        r_busy    <= 1'b1;
                        r_seq_idx <= 4'd0;
                        r_len     <= round_len;
                    end
                end
                ST_WAIT: begin
                    if (w_multi) begin
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_seq_idx   <= 4'd0;
                        r_fail      <= 1'b1;
                        r_fail_code <= FC_MULTI;
                    end else if (w_single) begin
                        r_press_valid <= 1'b1;
                        r_press_color <= w_color;
                        if (w_color != seq_color) begin
                            r_state     <= ST_IDLE;
                            r_busy      <= 1'b0;
                            r_seq_idx   <= 4'd0;
                            r_fail      <= 1'b1;
                            r_fail_code <= FC_COLOR;
                        end else if (w_last) begin
                            r_state    <= ST_IDLE;
                            r_busy     <= 1'b0;
                            r_seq_idx  <= 4'd0;
                            r_round_ok <= 1'b1;
                        end else begin
                            r_seq_idx <= r_seq_idx + 4'd1;
                        end
                    end else if (w_expired) begin
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_seq_idx   <= 4'd0;
                        r_fail      <= 1'b1;
                        r_fail_code <= FC_TIMEOUT;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign seq_idx     = r_seq_idx;
    assign busy        = r_busy;
    assign press_valid = r_press_valid;
    assign press_color = r_press_color;
    assign round_ok    = r_round_ok;
    assign fail        = r_fail;
    assign fail_code   = r_fail_code;

endmodule

// File: doc/simon_input_checker.md
SIMON_INPUT_CHECKER -- requirements
Module: simon_input_checker

Interface
REQ-001 Parameter MAX_LEN, default 16: maximum sequence length per round.
REQ-002 Parameter TIMEOUT, default 250000: idle cycles allowed between presses (5 s at 50 kHz).
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 n_reset  in  1  reset, synchronous, active-low.
REQ-005 btn_pulse  in  4  one-cycle release pulses from four Debounce instances; bit0 red, bit1 green, bit2 yellow, bit3 blue.
REQ-006 start  in  1  one-cycle request to begin checking a round.
REQ-007 round_len  in  5  number of presses expected this round, legal range 1..MAX_LEN; sampled on accepted start.
REQ-008 seq_color  in  2  expected color at seq_idx, combinationally valid the same cycle from sequence memory.
REQ-009 seq_idx  out  4  index of the press currently expected.
REQ-010 busy  out  1  high while a round is being checked.
REQ-011 press_valid  out  1  one-cycle pulse per accepted press, for tone/LED feedback.
REQ-012 press_color  out  2  encoded color of the last accepted press.
REQ-013 round_ok  out  1  one-cycle pulse: full sequence entered correctly.
REQ-014 fail  out  1  one-cycle pulse: round failed.
REQ-015 fail_code  out  2  01 wrong color, 10 timeout, 11 multiple buttons; holds until the next fail.

Function
REQ-016 States SHALL be IDLE and WAIT only; outputs SHALL be registered.
REQ-017 Color encoding SHALL be bit0->0, bit1->1, bit2->2, bit3->3.
REQ-018 In IDLE, start with round_len in 1..MAX_LEN SHALL enter WAIT with seq_idx=0, timer=0, len latched, busy=1 next cycle.
REQ-019 In IDLE, start with round_len 0 or >MAX_LEN SHALL be ignored; btn_pulse SHALL be ignored.
REQ-020 In WAIT, start SHALL be ignored.
REQ-021 In WAIT, with exactly one btn_pulse bit set at cycle t, press_valid=1 and press_color=encoded color at t+1.
REQ-022 If that color != seq_color at t: at t+1 fail=1, fail_code=01, state IDLE, busy=0.
REQ-023 If it matches and seq_idx==len-1: at t+1 round_ok=1, state IDLE, busy=0, seq_idx=0.
REQ-024 If it matches and seq_idx<len-1: seq_idx increments and timer clears at t+1.
REQ-025 In WAIT, two or more btn_pulse bits set: at t+1 fail=1, fail_code=11, press_valid=0, state IDLE.
REQ-026 Timer SHALL count every WAIT cycle without a press; at timer==TIMEOUT-1 with no press: fail=1, fail_code=10 next cycle, state IDLE.
REQ-027 A press coincident with the timeout cycle SHALL be evaluated as a press; the timeout SHALL NOT fire.
REQ-028 round_ok and fail SHALL never be asserted in the same cycle.
REQ-029 The timer SHALL be wide enough for TIMEOUT and SHALL NOT wrap while in WAIT.

Reset
REQ-030 n_reset low at a clock edge SHALL force IDLE, seq_idx=0, timer=0, busy=0, press_valid=0, press_color=0, round_ok=0, fail=0, fail_code=00.
REQ-031 Reset asserted mid-round SHALL abort the round without emitting fail or round_ok.

Structure
REQ-032 Shared package simon_pkg SHALL hold the color encodings, fail_code constants and the state enumeration.
REQ-033 The timeout counter SHALL be one sub-module, timeout_counter, with clear, enable and an expired flag.

Verification
REQ-034 round_len=3, seq colors 2,0,3; pulses bit2, bit0, bit3 -> three press_valid pulses, round_ok at the cycle after the third press, no fail.
REQ-035 round_len=2, seq 1,1; pulses bit1 then bit3 -> fail=1, fail_code=01 one cycle after bit3, busy=0.
REQ-036 Start, no press for TIMEOUT cycles -> fail=1, fail_code=10 exactly TIMEOUT cycles after WAIT entry; a press on the final cycle -> no timeout.
REQ-037 btn_pulse=4'b0101 in WAIT -> fail_code=11, press_valid=0; start with round_len=0 or 17 -> busy stays 0.
REQ-038 n_reset low after the second of four correct presses -> all outputs zero next edge, no fail or round_ok pulse, new start accepted.
